// File: rtl/cache_hier_pkg.sv
// Shared types and helpers for the two-level N-way read-cache hierarchy.
package cache_hier_pkg;

  typedef enum logic [2:0] {
    IDLE,
    L1_LK,
    L2_LK,
    MEM_WAIT,
    RESP
  } state_t;

  localparam int STAT_W = 16;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/cache_tag_array_nway.sv
// One level of an N-way set-associative, one-word-per-line read cache with true-LRU ages.
module cache_tag_array_nway
  import cache_hier_pkg::*;
#(
  parameter int SETS       = 4,
  parameter int WAYS       = 4,
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ADDR_WIDTH-1:0]     addr,
  output logic                      hit,
  output logic [clog2(WAYS)-1:0]    hit_way,
  output logic [DATA_WIDTH-1:0]     rd_data,
  input  logic                      fill_en,
  input  logic [DATA_WIDTH-1:0]     fill_data,
  input  logic                      touch_en,
  input  logic [clog2(WAYS)-1:0]    touch_way
);

  localparam int IW = clog2(SETS);
  localparam int AW = clog2(WAYS);
  localparam int TW = ADDR_WIDTH - IW;

  logic [WAYS-1:0]       valid_q [SETS];
  logic [TW-1:0]         tag_q   [SETS][WAYS];
  logic [DATA_WIDTH-1:0] data_q  [SETS][WAYS];
  logic [AW-1:0]         age_q   [SETS][WAYS];

  logic [IW-1:0] set_idx;
  logic [TW-1:0] tag_in;
  logic          found;
  logic [AW-1:0] victim;
  logic [AW-1:0] max_age;
  logic [AW-1:0] upd_way;

  assign set_idx = addr[IW-1:0];
  assign tag_in  = addr[ADDR_WIDTH-1:IW];
  assign upd_way = fill_en ? victim : touch_way;

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    rd_data = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[set_idx][w] && (tag_q[set_idx][w] == tag_in)) begin
        hit     = 1'b1;
        hit_way = AW'(w);
        rd_data = data_q[set_idx][w];
      end
    end
  end

  // Lowest invalid way wins; otherwise the oldest way (ages form a permutation).
  always_comb begin
    found   = 1'b0;
    victim  = '0;
    max_age = age_q[set_idx][0];
    for (int w = 0; w < WAYS; w++) begin
      if (!found && !valid_q[set_idx][w]) begin
        found  = 1'b1;
        victim = AW'(w);
      end
    end
    if (!found) begin
      for (int w = 1; w < WAYS; w++) begin
        if (age_q[set_idx][w] > max_age) begin
          max_age = age_q[set_idx][w];
          victim  = AW'(w);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) age_q[s][w] <= AW'(w);
      end
    end else if (fill_en || touch_en) begin
      if (fill_en) valid_q[set_idx][upd_way] <= 1'b1;
      for (int w = 0; w < WAYS; w++) begin
        if (AW'(w) == upd_way)
          age_q[set_idx][w] <= '0;
        else if (age_q[set_idx][w] < age_q[set_idx][upd_way])
          age_q[set_idx][w] <= age_q[set_idx][w] + AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[set_idx][victim]  <= tag_in;
      data_q[set_idx][victim] <= fill_data;
    end
  end

endmodule

// File: rtl/cache_hier_nway_ctrl.sv
// L1/L2 N-way read-cache controller with ready/valid request port and memory miss handshake.
// Optional hit/miss counters are built when CACHE_HIER_STATS_EN is defined.
module cache_hier_nway_ctrl
  import cache_hier_pkg::*;
#(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32,
  parameter int WAYS       = 4,
  parameter int L1_SETS    = 4,
  parameter int L2_SETS    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  resp_l1_hit,
  output logic                  resp_l2_hit,
  output logic                  mem_req_valid,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  input  logic                  mem_resp_valid,
  input  logic [DATA_WIDTH-1:0] mem_resp_data
`ifdef CACHE_HIER_STATS_EN
  ,
  output logic [STAT_W-1:0]     stat_l1_hits,
  output logic [STAT_W-1:0]     stat_l2_hits,
  output logic [STAT_W-1:0]     stat_misses
`endif
);

  localparam int AW = clog2(WAYS);

  state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] hold_data;
  logic                  hold_l1;
  logic                  hold_l2;

  logic                  l1_hit, l2_hit;
  logic [AW-1:0]         l1_hit_way, l2_hit_way;
  logic [DATA_WIDTH-1:0] l1_data, l2_data;
  logic                  l1_fill, l2_fill, l1_touch, l2_touch;
  logic [DATA_WIDTH-1:0] fill_data;

  cache_tag_array_nway #(
    .SETS(L1_SETS), .WAYS(WAYS), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)
  ) u_l1 (
    .clk(clk), .rst(rst), .addr(addr_q),
    .hit(l1_hit), .hit_way(l1_hit_way), .rd_data(l1_data),
    .fill_en(l1_fill), .fill_data(fill_data),
    .touch_en(l1_touch), .touch_way(l1_hit_way)
  );

  cache_tag_array_nway #(
    .SETS(L2_SETS), .WAYS(WAYS), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)
  ) u_l2 (
    .clk(clk), .rst(rst), .addr(addr_q),
    .hit(l2_hit), .hit_way(l2_hit_way), .rd_data(l2_data),
    .fill_en(l2_fill), .fill_data(fill_data),
    .touch_en(l2_touch), .touch_way(l2_hit_way)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // An L2 hit promotes its line into L1; a memory return fills both levels.
  always_comb begin
    state_d   = state_q;
    l1_fill   = 1'b0;
    l2_fill   = 1'b0;
    l1_touch  = 1'b0;
    l2_touch  = 1'b0;
    fill_data = l2_data;
    case (state_q)
      IDLE:     if (req_valid) state_d = L1_LK;
      L1_LK: begin
        if (l1_hit) begin
          l1_touch = 1'b1;
          state_d  = RESP;
        end else begin
          state_d  = L2_LK;
        end
      end
      L2_LK: begin
        if (l2_hit) begin
          l2_touch = 1'b1;
          l1_fill  = 1'b1;
          state_d  = RESP;
        end else begin
          state_d  = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        if (mem_resp_valid) begin
          l1_fill   = 1'b1;
          l2_fill   = 1'b1;
          fill_data = mem_resp_data;
          state_d   = RESP;
        end
      end
      RESP:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  assign req_ready     = (state_q == IDLE);
  assign mem_req_valid = (state_q == MEM_WAIT);
  assign mem_req_addr  = addr_q;

  always_ff @(posedge clk) begin
    if (l1_touch)     hold_data <= l1_data;
    else if (l1_fill) hold_data <= fill_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q      <= '0;
      hold_l1     <= 1'b0;
      hold_l2     <= 1'b0;
      resp_valid  <= 1'b0;
      resp_data   <= '0;
      resp_l1_hit <= 1'b0;
      resp_l2_hit <= 1'b0;
    end else begin
      resp_valid <= (state_q == RESP);
      if (state_q == IDLE && req_valid) addr_q <= req_addr;
      if (l1_touch || l1_fill) begin
        hold_l1 <= l1_touch;
        hold_l2 <= l1_fill && !l2_fill;
      end
      if (state_q == RESP) begin
        resp_data   <= hold_data;
        resp_l1_hit <= hold_l1;
        resp_l2_hit <= hold_l2;
      end
    end
  end

`ifdef CACHE_HIER_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_l1_hits <= '0;
      stat_l2_hits <= '0;
      stat_misses  <= '0;
    end else if (state_q == RESP) begin
      if (hold_l1) begin
        if (stat_l1_hits != '1) stat_l1_hits <= stat_l1_hits + STAT_W'(1);
      end else if (hold_l2) begin
        if (stat_l2_hits != '1) stat_l2_hits <= stat_l2_hits + STAT_W'(1);
      end else begin
        if (stat_misses != '1)  stat_misses  <= stat_misses + STAT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_cache_hier_nway_ctrl.sv
// Scoreboard bench for cache_hier_nway_ctrl: directed requests, queued expectations, decoupled monitor.
module tb_cache_hier_nway_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [10:0] req_addr;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_l1_hit;
  logic        resp_l2_hit;
  logic        mem_req_valid;
  logic [10:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
`ifdef CACHE_HIER_STATS_EN
  logic [15:0] stat_l1_hits, stat_l2_hits, stat_misses;
`endif

  cache_hier_nway_ctrl #(
    .ADDR_WIDTH(11), .DATA_WIDTH(32), .WAYS(4), .L1_SETS(4), .L2_SETS(16)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .resp_l1_hit(resp_l1_hit), .resp_l2_hit(resp_l2_hit),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
`ifdef CACHE_HIER_STATS_EN
    ,
    .stat_l1_hits(stat_l1_hits), .stat_l2_hits(stat_l2_hits), .stat_misses(stat_misses)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        l1;
    logic        l2;
    int          lat;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          resp_count = 0;
  int          mem_reqs = 0;
  logic [10:0] cur_addr = '0;

  localparam int MISS = 0, L1H = 1, L2H = 2;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (resp_valid) begin
      resp_count++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got data %h expected no response", resp_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("resp_data", resp_data, e.data);
        check("resp_l1_hit", {31'b0, resp_l1_hit}, {31'b0, e.l1});
        check("resp_l2_hit", {31'b0, resp_l2_hit}, {31'b0, e.l2});
        check("resp_latency", cyc - e.acc, e.lat);
      end
    end
  end

  // Memory model: word = 0xCAFE0000 | addr, delivered 3 cycles after the request appears.
  initial begin
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    forever begin
      @(negedge clk);
      if (mem_req_valid && !rst) begin
        mem_reqs++;
        check("mem_req_addr", {21'b0, mem_req_addr}, {21'b0, cur_addr});
        repeat (2) @(negedge clk);
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'hCAFE0000 | {21'b0, mem_req_addr};
        @(negedge clk);
        mem_resp_valid = 1'b0;
      end
    end
  end

  task automatic issue(input logic [10:0] a, input int kind);
    int   m0;
    int   t;
    exp_t e;
    @(negedge clk);
    t = 0;
    while (!req_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    req_valid = 1'b1;
    req_addr  = a;
    cur_addr  = a;
    m0        = mem_reqs;
    @(posedge clk);
    #1;
    e.acc  = cyc;
    e.data = 32'hCAFE0000 | {21'b0, a};
    e.l1   = (kind == L1H);
    e.l2   = (kind == L2H);
    e.lat  = (kind == L1H) ? 2 : (kind == L2H) ? 3 : 6;
    sb.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    t = 0;
    while (sb.size() != 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL resp_timeout: addr %h got no response expected one within 50 cycles", a);
      sb.delete();
    end
    check("mem_req_count", mem_reqs - m0, (kind == MISS) ? 1 : 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int t;
    int r0;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_addr  = '0;
    repeat (2) @(negedge clk);
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_mem_req_valid", {31'b0, mem_req_valid}, 32'd0);
    check("rst_resp_data", resp_data, 32'd0);
    check("rst_flags", {30'b0, resp_l1_hit, resp_l2_hit}, 32'd0);
    rst = 1'b0;

    // T1 cold miss, T2 L1 hit
    issue(11'h010, MISS);
    issue(11'h010, L1H);
`ifdef CACHE_HIER_STATS_EN
    check("stat_l1_t2", {16'b0, stat_l1_hits}, 32'd1);
    check("stat_l2_t2", {16'b0, stat_l2_hits}, 32'd0);
    check("stat_miss_t2", {16'b0, stat_misses}, 32'd1);
`endif

    // T3 L1 set-0 eviction served by L2
    do_reset();
    issue(11'h000, MISS);
    issue(11'h004, MISS);
    issue(11'h008, MISS);
    issue(11'h00C, MISS);
    issue(11'h010, MISS);
    issue(11'h000, L2H);
    issue(11'h000, L1H);
`ifdef CACHE_HIER_STATS_EN
    check("stat_l1_t3", {16'b0, stat_l1_hits}, 32'd1);
    check("stat_l2_t3", {16'b0, stat_l2_hits}, 32'd1);
    check("stat_miss_t3", {16'b0, stat_misses}, 32'd5);
`endif

    // T4 LRU victim: re-reading 0x000 makes 0x004 the victim
    do_reset();
    issue(11'h000, MISS);
    issue(11'h004, MISS);
    issue(11'h008, MISS);
    issue(11'h00C, MISS);
    issue(11'h000, L1H);
    issue(11'h010, MISS);
    issue(11'h000, L1H);
    issue(11'h004, L2H);

    // T5 reset while waiting on memory
    do_reset();
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = 11'h020;
    cur_addr  = 11'h020;
    @(negedge clk);
    req_valid = 1'b0;
    t = 0;
    while (!mem_req_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("t5_mem_req_seen", {31'b0, mem_req_valid}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("t5_mem_req_drop", {31'b0, mem_req_valid}, 32'd0);
    check("t5_ready_in_rst", {31'b0, req_ready}, 32'd1);
    r0 = resp_count;
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("t5_no_stray_resp", resp_count, r0);
    check("t5_ready_after", {31'b0, req_ready}, 32'd1);
    issue(11'h020, MISS);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
